strip_result_reader: RTL and testbench
======================================

STRIP_RESULT_READER -- requirements
Module: strip_result_reader

Interface
REQ-001 Parameter OUT_W, 222, output columns per strip (conv horizontal slide count).
REQ-002 Parameter OUT_H, 28, output rows per strip (conv vertical slide count).
REQ-003 Parameter RD_LAT, 1, read latency of the strip result BRAM in cycles (1 or 2).
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; arms reader.
REQ-007 unit_done  in  1  level from conv unit; strip result BRAM complete.
REQ-008 rd_addr  out  16  address to strip result BRAM read port.
REQ-009 rd_data  in  9  signed result word, valid RD_LAT cycles after rd_addr.
REQ-010 m_valid  out  1  stream word valid.
REQ-011 m_ready  in  1  downstream accepts word when m_valid && m_ready.
REQ-012 m_data  out  9  signed result word.
REQ-013 m_row  out  8  row index of m_data, 0..OUT_H-1.
REQ-014 m_col  out  8  column index of m_data, 0..OUT_W-1.
REQ-015 m_last  out  1  high with final word (row OUT_H-1, col OUT_W-1).
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse after final word is accepted.

Function
REQ-018 FSM states: IDLE, WAIT_DONE, READ, DRAIN, FINISH.
REQ-019 IDLE->WAIT_DONE on start; start ignored in all other states.
REQ-020 WAIT_DONE->READ on first cycle unit_done is sampled high; unit_done already high at start gives READ one cycle after WAIT_DONE is entered.
REQ-021 READ issues addresses 0..OUT_W*OUT_H-1 in order, one per cycle, only when in-flight reads plus buffered words < 2.
REQ-022 Read responses land in a 2-entry FIFO (skid buffer); FIFO never overflows under any m_ready pattern.
REQ-023 m_valid high whenever FIFO non-empty; m_data/m_row/m_col/m_last from FIFO head, stable while m_valid && !m_ready.
REQ-024 Simultaneous FIFO push and pop in one cycle keep occupancy unchanged with no data loss.
REQ-025 m_col increments per issued address, wrapping OUT_W-1->0 and incrementing m_row; row/col travel with data through the FIFO.
REQ-026 READ->DRAIN in cycle after last address issues; DRAIN->FINISH when FIFO empty and no reads in flight.
REQ-027 FINISH asserts done for exactly one cycle, then IDLE; rd_addr returns to 0.
REQ-028 With m_ready held high, first m_valid occurs RD_LAT+1 cycles after READ entry and throughput is one word per cycle sustained.
REQ-029 Total accepted words per run equals OUT_W*OUT_H (6216 at defaults), each exactly once, in address order.
REQ-030 unit_done deasserting during READ/DRAIN is ignored; run completes.

Reset
REQ-031 reset forces IDLE, FIFO empty, in-flight count 0, counters 0.
REQ-032 Reset values: rd_addr 0, m_valid 0, m_data 0, m_row 0, m_col 0, m_last 0, busy 0, done 0.
REQ-033 reset mid-run discards all buffered/in-flight data; no m_valid until next start+unit_done.

Configuration
REQ-034 Macro STRIP_READER_RELU_EN defined: m_data = 0 when FIFO head word negative, else unchanged; row/col/last unaffected.
REQ-035 Macro STRIP_READER_RELU_EN undefined: m_data is the BRAM word unchanged (signed pass-through).

Verification
REQ-036 Defaults, BRAM mem[i]=i mod 256 (9-bit), m_ready=1, start then unit_done -> 6216 words in order, m_last only at row 27 col 221, done one cycle after that acceptance.
REQ-037 m_ready toggling 1,0,0,1 repeating, RD_LAT=2 -> no loss/duplication, m_data stable while stalled, FIFO occupancy never exceeds 2.
REQ-038 mem[5]=-17: without macro m_data=-17 at (row 0,col 5); with STRIP_READER_RELU_EN m_data=0.
REQ-039 start pulse, unit_done held low 50 cycles -> rd_addr stays 0, m_valid 0, busy 1; then unit_done=1 -> reading begins.
REQ-040 reset asserted at word 1000 of a run -> all outputs reset values next edge; new start+unit_done yields full 6216-word run from address 0.
REQ-041 OUT_W=4, OUT_H=2, m_ready=1 -> coordinates (0,0),(0,1),(0,2),(0,3),(1,0)..(1,3), m_last on 8th word.

Source files
------------

// File: rtl/strip_result_reader.sv
// Streams a finished conv strip result BRAM out as row/col-tagged words; build with STRIP_READER_RELU_EN to clamp negatives to 0.
// Latency: first m_valid RD_LAT+1 cycles after READ entry, then one word per cycle with m_ready high.
// Backpressure: 2-entry skid FIFO; reads issue only while in-flight plus buffered (after this cycle's pop) is below 2.
module strip_result_reader #(
    parameter int OUT_W  = 222,
    parameter int OUT_H  = 28,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        unit_done,
    output logic [15:0] rd_addr,
    input  logic [8:0]  rd_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [8:0]  m_data,
    output logic [7:0]  m_row,
    output logic [7:0]  m_col,
    output logic        m_last,
    output logic        busy,
    output logic        done
);
    localparam logic [15:0] LAST_ADDR = 16'(OUT_W * OUT_H - 1);
    localparam logic [7:0]  LAST_COL  = 8'(OUT_W - 1);
    localparam logic [7:0]  LAST_ROW  = 8'(OUT_H - 1);

    typedef enum logic [2:0] {IDLE, WAIT_DONE, READ, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [8:0] dat;
        logic [7:0] row;
        logic [7:0] col;
        logic       last;
    } ent_t;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] addr_q;
    logic [7:0]  row_q;
    logic [7:0]  col_q;

    logic [RD_LAT-1:0] pv_q;
    logic [RD_LAT-1:0] plast_q;
    logic [7:0]        prow_q [RD_LAT];
    logic [7:0]        pcol_q [RD_LAT];

    ent_t       fifo_q [2];
    logic       wptr_q;
    logic       rptr_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    logic              push;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic [2:0]        inflight;
    logic [2:0]        credit;
    logic [RD_LAT-1:0] pv_shift;
    logic              drained;
    ent_t              head;

    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 3'(pv_q[i]);
        end
    end

    assign push       = pv_q[RD_LAT-1];
    assign pop        = (cnt_q != 2'd0) && m_ready;
    assign cnt_d      = cnt_q + 2'(push) - 2'(pop);
    assign credit     = inflight + 3'(cnt_q) - 3'(pop);
    assign issue      = (state_q == READ) && (credit < 3'd2);
    assign issue_last = issue && (addr_q == LAST_ADDR);
    assign pv_shift   = pv_q << 1;
    // Nothing issues in DRAIN, so the pipe empties once only its top stage is occupied.
    assign drained    = (cnt_d == 2'd0) && (pv_shift == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WAIT_DONE;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (unit_done) state_q <= READ;
                end
                READ: begin
                    if (issue_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= 16'd0;
            row_q  <= 8'd0;
            col_q  <= 8'd0;
        end else if (issue) begin
            if (issue_last) begin
                addr_q <= 16'd0;
                row_q  <= 8'd0;
                col_q  <= 8'd0;
            end else begin
                addr_q <= addr_q + 16'd1;
                if (col_q == LAST_COL) begin
                    col_q <= 8'd0;
                    row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end
        end
    end

    // Coordinates ride alongside the BRAM read so they meet rd_data at the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q    <= '0;
            plast_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                prow_q[i] <= 8'd0;
                pcol_q[i] <= 8'd0;
            end
        end else begin
            pv_q[0]    <= issue;
            plast_q[0] <= (row_q == LAST_ROW) && (col_q == LAST_COL);
            prow_q[0]  <= row_q;
            pcol_q[0]  <= col_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]    <= pv_q[i-1];
                plast_q[i] <= plast_q[i-1];
                prow_q[i]  <= prow_q[i-1];
                pcol_q[i]  <= pcol_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= {rd_data, prow_q[RD_LAT-1], pcol_q[RD_LAT-1], plast_q[RD_LAT-1]};
                wptr_q         <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_d;
        end
    end

    assign head    = fifo_q[rptr_q];
    assign m_valid = (cnt_q != 2'd0);
    assign m_row   = head.row;
    assign m_col   = head.col;
    assign m_last  = head.last;
`ifdef STRIP_READER_RELU_EN
    assign m_data  = head.dat[8] ? 9'd0 : head.dat;
`else
    assign m_data  = head.dat;
`endif
    assign rd_addr = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_strip_result_reader.sv
// Three readers (222x28 lat1, 222x28 lat2, 4x2 lat1) share one BRAM image; one is streamed at a time against a queue of expected words.
module tb_strip_result_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        start_s     [3];
    logic        unit_done_s [3];
    logic        m_ready_s   [3];
    logic [15:0] rd_addr_s   [3];
    logic [8:0]  rd_data_s   [3];
    logic        m_valid_s   [3];
    logic [8:0]  m_data_s    [3];
    logic [7:0]  m_row_s     [3];
    logic [7:0]  m_col_s     [3];
    logic        m_last_s    [3];
    logic        busy_s      [3];
    logic        done_s      [3];

    logic [8:0] mem [8192];
    logic [8:0] bp1 [3];
    logic [8:0] bp2 [3];

    int errors = 0;
    int checks = 0;
    int act = 0;

    logic [25:0] sb_q [$];

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bp1[k] <= mem[rd_addr_s[k][12:0]];
            bp2[k] <= bp1[k];
        end
    end
    assign rd_data_s[0] = bp1[0];
    assign rd_data_s[1] = bp2[1];
    assign rd_data_s[2] = bp1[2];

    strip_result_reader #(.OUT_W(222), .OUT_H(28), .RD_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .unit_done(unit_done_s[0]),
        .rd_addr(rd_addr_s[0]), .rd_data(rd_data_s[0]), .m_valid(m_valid_s[0]), .m_ready(m_ready_s[0]),
        .m_data(m_data_s[0]), .m_row(m_row_s[0]), .m_col(m_col_s[0]), .m_last(m_last_s[0]),
        .busy(busy_s[0]), .done(done_s[0])
    );
    strip_result_reader #(.OUT_W(222), .OUT_H(28), .RD_LAT(2)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .unit_done(unit_done_s[1]),
        .rd_addr(rd_addr_s[1]), .rd_data(rd_data_s[1]), .m_valid(m_valid_s[1]), .m_ready(m_ready_s[1]),
        .m_data(m_data_s[1]), .m_row(m_row_s[1]), .m_col(m_col_s[1]), .m_last(m_last_s[1]),
        .busy(busy_s[1]), .done(done_s[1])
    );
    strip_result_reader #(.OUT_W(4), .OUT_H(2), .RD_LAT(1)) dut2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .unit_done(unit_done_s[2]),
        .rd_addr(rd_addr_s[2]), .rd_data(rd_data_s[2]), .m_valid(m_valid_s[2]), .m_ready(m_ready_s[2]),
        .m_data(m_data_s[2]), .m_row(m_row_s[2]), .m_col(m_col_s[2]), .m_last(m_last_s[2]),
        .busy(busy_s[2]), .done(done_s[2])
    );

    function automatic int w_of(int k);
        return (k == 2) ? 4 : 222;
    endfunction

    function automatic int h_of(int k);
        return (k == 2) ? 2 : 28;
    endfunction

    // Packed as {last, row, col, data}.
    function automatic logic [25:0] exp_word(int k, int idx);
        int w;
        int h;
        logic [8:0] d;
        w = w_of(k);
        h = h_of(k);
        d = mem[idx];
`ifdef STRIP_READER_RELU_EN
        if (d[8]) d = 9'd0;
`endif
        return {(idx == w * h - 1), 8'(idx / w), 8'(idx % w), d};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [25:0] prev_word = '0;
    logic [25:0] cur_word;
    logic [25:0] exp_w;
    logic        last_acc = 1'b0;
    logic        last_acc2 = 1'b0;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          last_acc_cyc = 0;
    logic [8:0]  val05 = 9'h155;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            last_acc   = 1'b0;
            last_acc2  = 1'b0;
        end else begin
            cur_word = {m_last_s[act], m_row_s[act], m_col_s[act], m_data_s[act]};
            if (done_s[act] || last_acc) check("done_pulse", 32'(done_s[act]), 32'(last_acc));
            if (last_acc2) check("idle_after_done", 32'(busy_s[act]), 32'd0);
            if (prev_stall) check("stall_hold", 32'({m_valid_s[act], cur_word}), 32'({1'b1, prev_word}));
            last_acc2 = last_acc;
            last_acc  = 1'b0;
            if (m_valid_s[act] && m_ready_s[act]) begin
                if (sb_q.size() == 0) begin
                    check("extra_word", 32'(cur_word), 32'hFFFF_FFFF);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("word", 32'(cur_word), 32'(exp_w));
                end
                if (act == 0 && m_row_s[0] == 8'd0 && m_col_s[0] == 8'd5) val05 = m_data_s[0];
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
                last_acc_cyc = cyc;
                last_acc = m_last_s[act];
            end
            prev_stall = m_valid_s[act] && !m_ready_s[act];
            prev_word  = cur_word;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(int k);
        for (int i = 0; i < w_of(k) * h_of(k); i++) sb_q.push_back(exp_word(k, i));
    endtask

    task automatic pulse_start(int k);
        start_s[k] = 1'b1;
        step();
        start_s[k] = 1'b0;
    endtask

    task automatic check_reset(int k, string tag);
        check({tag, "_addr"}, 32'(rd_addr_s[k]), 32'd0);
        check({tag, "_outs"}, 32'({m_valid_s[k], m_data_s[k], m_row_s[k], m_col_s[k],
                                   m_last_s[k], busy_s[k], done_s[k]}), 32'd0);
    endtask

    task automatic wait_done(int k, int bound, bit toggle);
        int  n;
        int  ph;
        bit  got;
        n   = 0;
        ph  = 0;
        got = 1'b0;
        while (n < bound && !got) begin
            @(posedge clk);
            #1;
            if (toggle) begin
                m_ready_s[k] = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end
            @(negedge clk);
            got = done_s[k];
            n++;
        end
        check("done_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        m_ready_s[k] = 1'b1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8192; i++) mem[i] = 9'(i % 256);
        mem[5] = 9'h1EF;
        for (int k = 0; k < 3; k++) begin
            start_s[k]     = 1'b0;
            unit_done_s[k] = 1'b0;
            m_ready_s[k]   = 1'b1;
        end

        @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset(k, "reset");
        step();
        reset = 1'b0;

        // 4x2 geometry: coordinates and m_last on the 8th word.
        act = 2;
        unit_done_s[2] = 1'b1;
        push_run(2);
        pulse_start(2);
        wait_done(2, 200, 1'b0);

        // RD_LAT=2 under a 1,0,0,1 ready pattern.
        step();
        act = 1;
        unit_done_s[1] = 1'b1;
        push_run(1);
        pulse_start(1);
        wait_done(1, 40000, 1'b1);

        // unit_done already high: WAIT_DONE, READ, then RD_LAT+1 to first word.
        step();
        act = 0;
        unit_done_s[0] = 1'b1;
        push_run(0);
        first_acc = -1;
        pulse_start(0);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (m_valid_s[0]) break;
        end
        check("first_valid_latency", 32'(n), 32'd4);
        wait_done(0, 10000, 1'b0);
        check("throughput", 32'(last_acc_cyc - first_acc), 32'd6215);
`ifdef STRIP_READER_RELU_EN
        check("relu_word5", 32'(val05), 32'd0);
`else
        check("signed_word5", 32'(val05), 32'h1EF);
`endif

        // Armed with unit_done low: must hold off reading.
        step();
        unit_done_s[0] = 1'b0;
        pulse_start(0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("wait_hold", 32'({rd_addr_s[0], m_valid_s[0], busy_s[0]}), 32'({16'd0, 1'b0, 1'b1}));
        end
        step();
        push_run(0);
        acc_cnt = 0;
        unit_done_s[0] = 1'b1;
        n = 0;
        while (n < 5000 && acc_cnt < 1000) begin
            step();
            n++;
        end
        check("reached_word_1000", 32'(acc_cnt >= 1000), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset(0, "midrun_reset");
        sb_q.delete();
        unit_done_s[0] = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({m_valid_s[0], busy_s[0]}), 32'd0);
        end

        // Full run from address 0 after the mid-run reset.
        step();
        push_run(0);
        unit_done_s[0] = 1'b1;
        pulse_start(0);
        wait_done(0, 10000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
